// File: rtl/mult4u_acc_stage.sv
// mult4u_acc_stage: accumulate stage behind the unsigned 4x4 multiplier.
// Sums a group of handshaked products and presents the group total downstream.
// Groups close after LEN accepted beats or on a beat marked in_last.
// Optional feature: define MULT4U_RESIDUE_CHK_EN to enable a mod-3 residue check of
// each product. The check drives out_err and err_cnt. Without the macro, both are tied to 0.
module mult4u_acc_stage #(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [7:0]       in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             out_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [8:0] LEN_W = 9'(LEN);

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf;

  logic             w_accept;
  logic             w_take;
  logic             w_close;
  logic [ACC_W:0]   w_sum_ext;
  logic [8:0]       w_cnt_inc;

  // Handshake qualifiers depend only on registered state and the sampled inputs.
  assign w_accept  = in_valid & (r_state == ACCUM);
  assign w_take    = out_ready & (r_state == HOLD);
  // One extra bit on the sum exposes the carry out of the accumulator's MSB.
  assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, in_p};
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_close   = in_last | (w_cnt_inc == LEN_W);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: close the group on the last accepted beat, reopen when the result is taken.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM: if (w_accept && w_close) w_state_next = HOLD;
      HOLD:  if (out_ready)           w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  // Accumulator, beat counter and sticky overflow. The take edge clears them for the next group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= 8'd0;
      r_ovf <= 1'b0;
    end else if (w_take) begin
      r_acc <= '0;
      r_cnt <= 8'd0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum_ext[ACC_W-1:0];
      r_cnt <= w_cnt_inc[7:0];
      if (w_sum_ext[ACC_W]) r_ovf <= 1'b1;
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;

`ifdef MULT4U_RESIDUE_CHK_EN
  logic       r_err;
  logic [7:0] r_err_cnt;
  logic [3:0] w_res_prod;
  logic       w_mismatch;

  function automatic logic [1:0] mod3(input logic [7:0] v);
    logic [7:0] r;
    r = v % 8'd3;
    return r[1:0];
  endfunction

  // The residue of the product must equal the product of the operand residues, mod 3.
  assign w_res_prod = {2'b00, mod3({4'b0000, in_a})} * {2'b00, mod3({4'b0000, in_b})};
  assign w_mismatch = (mod3({4'b0000, w_res_prod}) != mod3(in_p));

  // Per-group sticky error flag. It includes a mismatch on the closing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_take) begin
      r_err <= 1'b0;
    end else if (w_accept && w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  // Lifetime mismatch counter. It saturates at 255 and only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_accept && w_mismatch && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign out_err = r_err;
  assign err_cnt = r_err_cnt;
`else
  // Operands are only needed by the residue checker.
  logic w_unused_operands;
  assign w_unused_operands = ^{in_a, in_b};
  assign out_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mult4u_acc_stage.sv
// Testbench for mult4u_acc_stage.
// Two instances share all inputs. The ACC_W=12 instance checks plain sums.
// The ACC_W=8 instance exercises wrap and overflow.
// A group-level reference model predicts each group total, error flag and the error count.
module tb_mult4u_acc_stage;

`ifdef MULT4U_RESIDUE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0] in_a = 4'd0, in_b = 4'd0;
  logic [7:0] in_p = 8'd0;
  logic       in_ready, out_valid, out_ovf, out_err;
  logic [11:0] out_sum;
  logic [7:0] err_cnt;
  logic       in_ready8, out_valid8, out_ovf8, out_err8;
  logic [7:0] out_sum8, err_cnt8;

  mult4u_acc_stage #(.LEN(4), .ACC_W(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_p(in_p), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_err(out_err), .err_cnt(err_cnt));

  mult4u_acc_stage #(.LEN(4), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .in_p(in_p), .in_last(in_last),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
    .out_ovf(out_ovf8), .out_err(out_err8), .err_cnt(err_cnt8));

  always #5 clk = ~clk;

  typedef struct {
    int total;
    bit err;
  } grp_t;

  grp_t exp_q[$];
  int   g_total = 0, g_n = 0, m_errcnt = 0;
  bit   g_err = 1'b0;
  int   errors = 0, checks = 0;

  // Captured result of one group, as seen in HOLD.
  logic [11:0] c_s12;
  logic [7:0]  c_s8;
  logic        c_o12, c_o8, c_e12;
  grp_t        c_exp;

  // Drive one beat and wait (bounded) for its acceptance, then update the reference model.
  task automatic send_beat(input int a, input int b, input int p, input bit last);
    int waitc = 0;
    @(negedge clk);
    in_a = a[3:0]; in_b = b[3:0]; in_p = p[7:0]; in_last = last; in_valid = 1'b1;
    while (in_ready !== 1'b1) begin
      waitc++;
      if (waitc > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    g_total += p;
    g_n++;
    if (CHK && (((a * b) % 3) != (p % 3))) begin
      g_err = 1'b1;
      if (m_errcnt < 255) m_errcnt++;
    end
    if (last || g_n == 4) begin
      exp_q.push_back('{g_total, g_err});
      g_total = 0; g_n = 0; g_err = 1'b0;
    end
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait (bounded) for a result, hold it for 'hold' cycles, capture it, and take it.
  task automatic take_result(input int hold);
    int waitc = 0;
    @(negedge clk);
    while (out_valid !== 1'b1) begin
      waitc++;
      if (waitc > 50) begin
        checks++; errors++;
        $display("FAIL result_timeout out_valid=%b required 1", out_valid);
        return;
      end
      @(negedge clk);
    end
    repeat (hold) @(negedge clk);
    c_s12 = out_sum; c_o12 = out_ovf; c_e12 = out_err; c_s8 = out_sum8; c_o8 = out_ovf8;
    if (exp_q.size() > 0) c_exp = exp_q.pop_front();
    else c_exp = '{-1, 1'b0};
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    $display("group: sum12=%0d ovf12=%0d err=%0d sum8=%0d ovf8=%0d err_cnt=%0d (model total=%0d)",
             c_s12, c_o12, c_e12, c_s8, c_o8, err_cnt, c_exp.total);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 12'd0) begin errors++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
    checks++; if ({out_ovf, out_err, err_cnt} !== 10'd0) begin errors++; $display("FAIL reset_flags got=%b exp=0", {out_ovf, out_err, err_cnt}); end
    checks++; if ({in_ready8, out_valid8, out_sum8} !== {2'b10, 8'd0}) begin errors++; $display("FAIL reset_dut8 got=%b exp=10_00000000", {in_ready8, out_valid8, out_sum8}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_group();
    send_beat(3, 5, 15, 1'b0);
    send_beat(15, 15, 225, 1'b0);
    send_beat(0, 9, 0, 1'b0);
    send_beat(7, 7, 49, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency out_valid=%b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    take_result(0);
    checks++; if (c_s12 !== 12'd289) begin errors++; $display("FAIL full_sum got=%0d exp=289", c_s12); end
    checks++; if ({c_o12, c_e12} !== 2'b00) begin errors++; $display("FAIL full_flags got=%b exp=00", {c_o12, c_e12}); end
    checks++; if (c_s8 !== 8'(c_exp.total % 256) || c_o8 !== 1'(c_exp.total >= 256)) begin
      errors++; $display("FAIL full_sum8 got=%0d/%b exp=%0d/%b", c_s8, c_o8, c_exp.total % 256, c_exp.total >= 256);
    end
  endtask

  task automatic test_last();
    send_beat(2, 3, 6, 1'b0);
    send_beat(4, 4, 16, 1'b1);
    take_result(0);
    checks++; if (c_s12 !== 12'd22) begin errors++; $display("FAIL last_sum got=%0d exp=22", c_s12); end
    for (int i = 0; i < 4; i++) send_beat(1, 1, 1, 1'b0);
    take_result(1);
    checks++; if (c_s12 !== 12'd4) begin errors++; $display("FAIL last_next_group got=%0d exp=4", c_s12); end
  endtask

  task automatic test_ovf();
    send_beat(15, 15, 225, 1'b0);
    send_beat(15, 15, 225, 1'b1);
    take_result(0);
    checks++; if (c_s8 !== 8'd194 || c_o8 !== 1'b1) begin errors++; $display("FAIL ovf8 got=%0d/%b exp=194/1", c_s8, c_o8); end
    checks++; if (c_s12 !== 12'd450 || c_o12 !== 1'b0) begin errors++; $display("FAIL ovf12 got=%0d/%b exp=450/0", c_s12, c_o12); end
  endtask

  task automatic test_residue();
    send_beat(15, 15, 224, 1'b1);
    take_result(0);
    checks++; if (c_e12 !== CHK) begin errors++; $display("FAIL residue_err got=%b exp=%b", c_e12, CHK); end
    checks++; if (err_cnt !== 8'(CHK)) begin errors++; $display("FAIL residue_cnt got=%0d exp=%0d", err_cnt, CHK); end
    send_beat(1, 2, 2, 1'b0);
    send_beat(3, 3, 9, 1'b1);
    take_result(0);
    checks++; if (c_e12 !== 1'b0) begin errors++; $display("FAIL residue_clean_err got=%b exp=0", c_e12); end
    checks++; if (err_cnt !== 8'(m_errcnt)) begin errors++; $display("FAIL residue_clean_cnt got=%0d exp=%0d", err_cnt, m_errcnt); end
  endtask

  task automatic test_backpressure();
    send_beat(1, 5, 5, 1'b0);
    send_beat(2, 2, 4, 1'b0);
    send_beat(3, 3, 9, 1'b0);
    send_beat(4, 4, 16, 1'b0);
    c_exp = exp_q.pop_front();
    @(negedge clk);
    in_a = 4'd5; in_b = 4'd5; in_p = 8'd25; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 12'(c_exp.total)) begin
        errors++; $display("FAIL bp_hold cycle=%0d in_ready=%b out_valid=%b sum=%0d exp=0/1/%0d", i, in_ready, out_valid, out_sum, c_exp.total);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
    checks++; if (out_sum !== 12'd0) begin errors++; $display("FAIL bp_no_accept sum=%0d exp=0", out_sum); end
    $display("backpressure: held sum=%0d", c_exp.total);
  endtask

  task automatic test_reset_midgroup();
    send_beat(9, 9, 81, 1'b0);
    send_beat(8, 8, 64, 1'b0);
    @(negedge clk);
    checks++; if (out_sum !== 12'd145) begin errors++; $display("FAIL mid_partial sum=%0d exp=145", out_sum); end
    rst_n = 1'b0;
    #1;
    g_total = 0; g_n = 0; g_err = 1'b0; m_errcnt = 0;
    checks++; if ({in_ready, out_valid, out_ovf, out_err} !== 4'b1000 || out_sum !== 12'd0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_reset rdy/vld/ovf/err=%b sum=%0d cnt=%0d exp=1000/0/0", {in_ready, out_valid, out_ovf, out_err}, out_sum, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(1, 1, 1, 1'b0);
    send_beat(2, 2, 4, 1'b0);
    send_beat(3, 3, 9, 1'b0);
    send_beat(2, 5, 10, 1'b0);
    take_result(0);
    checks++; if (c_s12 !== 12'd24) begin errors++; $display("FAIL mid_new_group sum=%0d exp=24", c_s12); end
  endtask

  task automatic test_random();
    for (int g = 0; g < 40; g++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) begin
        int a, b, p;
        a = int'($urandom_range(0, 15));
        b = int'($urandom_range(0, 15));
        p = a * b;
        if ($urandom_range(0, 4) == 0) p = (p + int'($urandom_range(1, 255))) % 256;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_beat(a, b, p, k == len - 1);
      end
      take_result(int'($urandom_range(0, 2)));
      checks++;
      if (c_s12 !== 12'(c_exp.total % 4096) || c_o12 !== 1'(c_exp.total >= 4096) || c_e12 !== c_exp.err) begin
        errors++; $display("FAIL rand_dut12 g=%0d got=%0d/%b/%b exp=%0d/%b/%b", g, c_s12, c_o12, c_e12, c_exp.total, c_exp.total >= 4096, c_exp.err);
      end
      checks++;
      if (c_s8 !== 8'(c_exp.total % 256) || c_o8 !== 1'(c_exp.total >= 256)) begin
        errors++; $display("FAIL rand_dut8 g=%0d got=%0d/%b exp=%0d/%b", g, c_s8, c_o8, c_exp.total % 256, c_exp.total >= 256);
      end
      checks++;
      if (err_cnt !== 8'(m_errcnt)) begin
        errors++; $display("FAIL rand_err_cnt g=%0d got=%0d exp=%0d", g, err_cnt, m_errcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_last();
    test_ovf();
    test_residue();
    test_backpressure();
    test_reset_midgroup();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult4u_acc_stage.md
# mult4u_acc_stage

Sequential accumulate stage placed directly downstream of the combinational unsigned 4-bit multiplier. Each handshaked beat delivers the multiplier's operands and 8-bit product; the stage sums a group of products into an accumulator and hands the group total downstream. An optional mod-3 residue check detects faults that corrupt the product.

## Interface
- `LEN`, default 4: maximum products per group, legal range 1..255.
- `ACC_W`, default 12: accumulator and output sum width, minimum 8.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream beat valid.
- `in_ready` output 1: stage accepts a beat this cycle.
- `in_a` input 4: multiplier operand A.
- `in_b` input 4: multiplier operand B.
- `in_p` input 8: multiplier product, O[7:0].
- `in_last` input 1: closes the group early on this beat.
- `out_valid` output 1: group result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output ACC_W: group sum, modulo 2^ACC_W.
- `out_ovf` output 1: sum wrapped during the group.
- `out_err` output 1: residue mismatch seen in the group.
- `err_cnt` output 8: total residue mismatches since reset, saturating.

## Operation
- Two states: ACCUM and HOLD. Reset enters ACCUM with acc=0, cnt=0, ovf=0, err=0, and err_cnt=0.
- Reset values of outputs: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_err=0, err_cnt=0.
- In_ready is 1 only in ACCUM. out_valid is 1 only in HOLD.
- Accept means in_valid & in_ready. On accept, acc <= acc + zero-extended in_p, truncated to ACC_W. A carry out of bit ACC_W-1 sets sticky ovf. cnt increments.
- Transition to HOLD occurs on the accept where cnt+1 == LEN or in_last=1. The final beat is included in the sum.
- In HOLD, out_sum, out_ovf, and out_err are the registered group values and stay stable while out_ready=0.
- HOLD to ACCUM occurs on out_valid & out_ready. That same edge clears acc, cnt, ovf, and err. err_cnt is not cleared.
- Beats are never dropped. In_valid during HOLD is back-pressured.
- Asynchronous reset mid-group discards the partial sum. The first accepted beat after reset starts a new group.

## Timing
- The first accepted beat needs no prior cycle. Max one beat per cycle in ACCUM.
- out_valid rises on the cycle after the closing beat is accepted.
- Minimum group period is LEN+1 cycles: LEN accept cycles plus one HOLD cycle with out_ready=1.
- in_ready is low from the cycle after the closing accept through the cycle in which the result is taken.
- Handshake inputs are sampled only at the rising edge of clk. out_* and in_ready are driven from registers and state, with no combinational path from in_valid or out_ready.

## Configuration
- `MULT4U_RESIDUE_CHK_EN` defined:
  - On each accept, compare ((in_a mod 3)*(in_b mod 3)) mod 3 with in_p mod 3.
  - A mismatch sets sticky err for the group and increments err_cnt, saturating at 255.
  - A mismatch on the closing beat is included in out_err.
- `MULT4U_RESIDUE_CHK_EN` undefined: no checker logic; out_err and err_cnt are tied to 0. Ports are unchanged.

## Test plan
- LEN=4, ACC_W=12, beats (3,5,15), (15,15,225), (0,9,0), (7,7,49) on consecutive cycles -> out_valid on the next cycle with out_sum=289, out_ovf=0, out_err=0.
- Beats (2,3,6), (4,4,16) with in_last on the second -> out_sum=22 after 2 beats. The next group starts from 0.
- ACC_W=8, beats (15,15,225), (15,15,225) with in_last -> out_sum=194, out_ovf=1.
- With the checker enabled, beat (15,15,224) -> out_err=1 and err_cnt=1. The following group of clean beats -> out_err=0 and err_cnt still 1.
- Result held with out_ready=0 for 3 cycles, while in_valid=1 -> in_ready=0, out_sum stable, no beat accepted. out_ready=1 -> in_ready=1 the next cycle.
- rst_n pulsed low after 2 of 4 beats -> all outputs return to reset values immediately. The next 4 beats sum only themselves.
